// File: rtl/lcd_avalon_slave.sv
// ----------------------------------------------------------------------------
// lcd_avalon_slave
//
// Avalon-MM slave that turns byte writes from the LCD menu master into
// HD44780-style 8-bit bus cycles. waitrequest is held for the whole LCD bus
// cycle plus the controller's execution time, so the master only needs to
// follow the Avalon handshake and never has to time anything itself.
//
// Register map:
//   address 0 : instruction register (RS=0). Reads return {7'b0, busy}.
//   address 1 : data register (RS=1). Reads return the last byte written.
//
// Ports:
//   clk          system clock (50 MHz nominal)
//   reset        synchronous, active-low reset
//   address      0 = instruction, 1 = data
//   chipselect   slave select
//   byteenable   single byte lane, always 1; not used
//   read, write  Avalon strobes
//   writedata    byte to send to the LCD
//   waitrequest  stall to the master (combinational)
//   readdata     status / readback byte (registered)
//   response     always OKAY
//   lcd_data     DB7..DB0
//   lcd_rs       register select
//   lcd_rw       read/write, tied low (write only)
//   lcd_en       enable strobe
//   lcd_on       LCD power, constant 1
//   lcd_blon     backlight, constant 1
// ----------------------------------------------------------------------------
module lcd_avalon_slave #(
   parameter int POWERUP_CYCLES   = 800000,
   parameter int SETUP_CYCLES     = 2,
   parameter int EN_CYCLES        = 16,
   parameter int HOLD_CYCLES      = 2,
   parameter int EXEC_CYCLES      = 2000,
   parameter int LONG_EXEC_CYCLES = 82000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       address,
   input  logic       chipselect,
   input  logic       byteenable,
   input  logic       read,
   input  logic       write,
   input  logic [7:0] writedata,
   output logic       waitrequest,
   output logic [7:0] readdata,
   output logic [1:0] response,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic       lcd_on,
   output logic       lcd_blon
);

   localparam int CNT_W = 20;

   // Counter reload values: a state lasts exactly N cycles when loaded with N-1.
   localparam logic [CNT_W-1:0] POWERUP_LOAD = CNT_W'(POWERUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] EN_LOAD      = CNT_W'(EN_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] EXEC_LOAD    = CNT_W'(EXEC_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_LOAD    = CNT_W'(LONG_EXEC_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_IDLE,
      ST_SETUP,
      ST_ENABLE,
      ST_HOLD,
      ST_EXEC,
      ST_DONE,
      ST_RD_ACK
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] count_reg;
   logic             rs_reg;
   logic [7:0]       data_reg;
   logic [7:0]       last_data_reg;
   logic [7:0]       readdata_reg;
   logic             en_reg;

   logic             ack;
   logic             busy;
   logic             cnt_zero;
   logic             long_cmd;
   logic             unused_ok;

   // ack is only ever true for a single cycle: DONE and RD_ACK both fall
   // straight back to IDLE, so the master sees exactly one waitrequest-low cycle.
   assign ack         = (state_reg == ST_DONE) || (state_reg == ST_RD_ACK);
   assign waitrequest = chipselect & (read | write) & ~ack;
   assign busy        = (state_reg != ST_IDLE);
   assign cnt_zero    = (count_reg == '0);

   // Clear display (0x01) and return home (0x02/0x03, DB0 is don't-care)
   // need the long execution time; everything else uses the short one.
   assign long_cmd = ~rs_reg &
                     ((data_reg == 8'h01) || (data_reg == 8'h02) || (data_reg == 8'h03));

   assign readdata = readdata_reg;
   assign response = 2'b00;
   assign lcd_data = data_reg;
   assign lcd_rs   = rs_reg;
   assign lcd_rw   = 1'b0;
   assign lcd_en   = en_reg;
   assign lcd_on   = 1'b1;
   assign lcd_blon = 1'b1;

   assign unused_ok = &{1'b0, byteenable};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg     <= ST_POWERUP;
         count_reg     <= POWERUP_LOAD;
         en_reg        <= 1'b0;
         rs_reg        <= 1'b0;
         data_reg      <= 8'h00;
         readdata_reg  <= 8'h00;
         last_data_reg <= 8'h00;
      end else begin
         case (state_reg)
            ST_POWERUP: begin
               if (cnt_zero) begin
                  state_reg <= ST_IDLE;
               end else begin
                  count_reg <= count_reg - CNT_W'(1);
               end
            end

            ST_IDLE: begin
               // Write wins over a simultaneous read.
               if (chipselect && write) begin
                  rs_reg    <= address;
                  data_reg  <= writedata;
                  count_reg <= SETUP_LOAD;
                  state_reg <= ST_SETUP;
               end else if (chipselect && read) begin
                  readdata_reg <= address ? last_data_reg : {7'b0, busy};
                  state_reg    <= ST_RD_ACK;
               end
            end

            ST_SETUP: begin
               if (cnt_zero) begin
                  en_reg    <= 1'b1;
                  count_reg <= EN_LOAD;
                  state_reg <= ST_ENABLE;
               end else begin
                  count_reg <= count_reg - CNT_W'(1);
               end
            end

            ST_ENABLE: begin
               if (cnt_zero) begin
                  en_reg    <= 1'b0;
                  count_reg <= HOLD_LOAD;
                  state_reg <= ST_HOLD;
               end else begin
                  count_reg <= count_reg - CNT_W'(1);
               end
            end

            ST_HOLD: begin
               if (cnt_zero) begin
                  count_reg <= long_cmd ? LONG_LOAD : EXEC_LOAD;
                  state_reg <= ST_EXEC;
               end else begin
                  count_reg <= count_reg - CNT_W'(1);
               end
            end

            ST_EXEC: begin
               if (cnt_zero) begin
                  last_data_reg <= data_reg;
                  state_reg     <= ST_DONE;
               end else begin
                  count_reg <= count_reg - CNT_W'(1);
               end
            end

            // If the master already dropped write, ack goes unseen and the
            // transfer simply ends here.
            ST_DONE: begin
               state_reg <= ST_IDLE;
            end

            ST_RD_ACK: begin
               state_reg <= ST_IDLE;
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_avalon_slave.sv
// ----------------------------------------------------------------------------
// tb_lcd_avalon_slave
//
// Scoreboard bench for lcd_avalon_slave. Stimulus tasks push the expected
// LCD enable pulses and Avalon completions into queues; two monitor processes
// pop and compare whenever the DUT raises lcd_en or drops waitrequest.
// ----------------------------------------------------------------------------
module tb_lcd_avalon_slave;

   localparam int P_POWERUP = 10;
   localparam int P_SETUP   = 2;
   localparam int P_EN      = 4;
   localparam int P_HOLD    = 2;
   localparam int P_EXEC    = 8;
   localparam int P_LONG    = 20;

   // Waitrequest-high cycles for a write accepted in IDLE: 1+2+4+2+exec.
   localparam int LAT_SHORT = 17;
   localparam int LAT_LONG  = 29;

   logic       clk;
   logic       reset;
   logic       address;
   logic       chipselect;
   logic       byteenable;
   logic       read;
   logic       write;
   logic [7:0] writedata;
   logic       waitrequest;
   logic [7:0] readdata;
   logic [1:0] response;
   logic [7:0] lcd_data;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;
   logic       lcd_on;
   logic       lcd_blon;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         width;
   } en_t;

   typedef struct {
      bit         is_read;
      logic [7:0] rdata;
      int         lat;
   } ack_t;

   en_t  en_q[$];
   ack_t ack_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   lcd_avalon_slave #(
      .POWERUP_CYCLES  (P_POWERUP),
      .SETUP_CYCLES    (P_SETUP),
      .EN_CYCLES       (P_EN),
      .HOLD_CYCLES     (P_HOLD),
      .EXEC_CYCLES     (P_EXEC),
      .LONG_EXEC_CYCLES(P_LONG)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .byteenable (byteenable),
      .read       (read),
      .write      (write),
      .writedata  (writedata),
      .waitrequest(waitrequest),
      .readdata   (readdata),
      .response   (response),
      .lcd_data   (lcd_data),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_en     (lcd_en),
      .lcd_on     (lcd_on),
      .lcd_blon   (lcd_blon)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // One Avalon access; entered just after a rising edge, leaves just after
   // the rising edge that completes the access.
   task automatic access(input bit rd, input bit wr, input bit adr, input logic [7:0] wd);
      int n;
      chipselect = 1'b1;
      read       = rd;
      write      = wr;
      address    = adr;
      writedata  = wd;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (waitrequest && n < 400);
      chk("access_done", waitrequest, 0);
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
   endtask

   task automatic wr_tx(input bit adr, input logic [7:0] wd, input int lat);
      en_t  e;
      ack_t a;
      e.rs = adr; e.data = wd; e.width = P_EN;
      a.is_read = 1'b0; a.rdata = 8'h00; a.lat = lat;
      en_q.push_back(e);
      ack_q.push_back(a);
      access(1'b0, 1'b1, adr, wd);
   endtask

   task automatic rd_tx(input bit adr, input logic [7:0] exp_data);
      ack_t a;
      a.is_read = 1'b1; a.rdata = exp_data; a.lat = 1;
      ack_q.push_back(a);
      access(1'b1, 1'b0, adr, 8'h00);
   endtask

   // Completion monitor: counts waitrequest-high cycles of the current access
   // and checks each completion against the head of ack_q.
   initial begin
      int   acc_cnt;
      ack_t a;
      acc_cnt = 0;
      forever begin
         @(negedge clk);
         if (chipselect && (read || write)) begin
            if (waitrequest) begin
               acc_cnt++;
            end else begin
               chk("ack_expected", int'(ack_q.size() > 0), 1);
               if (ack_q.size() > 0) begin
                  a = ack_q.pop_front();
                  $display("ack: %s addr=%0d wdata=%02h latency=%0d readdata=%02h",
                           a.is_read ? "read " : "write", address, writedata, acc_cnt, readdata);
                  if (a.lat >= 0) chk("latency", acc_cnt, a.lat);
                  if (a.is_read) chk("readdata", readdata, a.rdata);
               end
               acc_cnt = 0;
            end
         end
      end
   end

   // LCD bus monitor: checks RS/DATA at each EN rise, the pulse width at each
   // EN fall, and that the master is still stalled while EN is high.
   initial begin
      logic en_prev;
      int   en_w;
      int   exp_w;
      en_t  e;
      en_prev = 1'b0;
      en_w    = 0;
      exp_w   = P_EN;
      forever begin
         @(negedge clk);
         if (lcd_en === 1'b1) begin
            if (!en_prev) begin
               chk("en_expected", int'(en_q.size() > 0), 1);
               if (en_q.size() > 0) begin
                  e = en_q.pop_front();
                  $display("lcd: rs=%0d data=%02h", lcd_rs, lcd_data);
                  chk("lcd_rs", lcd_rs, e.rs);
                  chk("lcd_data", lcd_data, e.data);
                  exp_w = e.width;
               end
               en_w = 0;
            end
            en_w++;
            chk("en_while_stalled", waitrequest, 1);
            en_prev = 1'b1;
         end else begin
            if (en_prev) chk("en_width", en_w, exp_w);
            en_prev = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      string msg;
      en_t   e;
      ack_t  a;
      msg = "Hello World 123";

      reset      = 1'b0;
      address    = 1'b0;
      chipselect = 1'b0;
      byteenable = 1'b1;
      read       = 1'b0;
      write      = 1'b0;
      writedata  = 8'h00;

      // Reset held for 3 edges; check reset state in between.
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_lcd_en", lcd_en, 0);
      chk("rst_lcd_rs", lcd_rs, 0);
      chk("rst_lcd_data", lcd_data, 0);
      chk("rst_readdata", readdata, 0);
      chk("rst_response", response, 0);
      chk("rst_lcd_rw", lcd_rw, 0);
      chk("rst_lcd_on", lcd_on, 1);
      chk("rst_lcd_blon", lcd_blon, 1);
      chk("rst_idle_waitreq", waitrequest, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // First write issued immediately: stalls through POWERUP (10) then 17.
      wr_tx(1'b1, 8'h41, P_POWERUP + LAT_SHORT);

      // Long vs short execution times.
      wr_tx(1'b0, 8'h01, LAT_LONG);
      wr_tx(1'b0, 8'h38, LAT_SHORT);
      wr_tx(1'b0, 8'h02, LAT_LONG);
      wr_tx(1'b0, 8'h03, LAT_LONG);
      wr_tx(1'b0, 8'h04, LAT_SHORT);
      wr_tx(1'b1, 8'h01, LAT_SHORT);

      // Back-to-back 16-byte stream: clear then 15 characters.
      wr_tx(1'b0, 8'h01, LAT_LONG);
      for (int i = 0; i < 15; i++) begin
         wr_tx(1'b1, msg[i], LAT_SHORT);
      end

      // Reads.
      rd_tx(1'b0, 8'h00);
      wr_tx(1'b1, 8'h5A, LAT_SHORT);
      rd_tx(1'b1, 8'h5A);

      // Read with chipselect low: no stall, readdata unchanged.
      address = 1'b1;
      read    = 1'b1;
      @(negedge clk);
      chk("nocs_waitreq", waitrequest, 0);
      @(negedge clk);
      chk("nocs_readdata", readdata, 8'h5A);
      @(posedge clk);
      #1;
      read = 1'b0;

      // read & write together: write is performed, no separate read ack.
      en_q.push_back('{rs: 1'b1, data: 8'h33, width: P_EN});
      ack_q.push_back('{is_read: 1'b0, rdata: 8'h00, lat: LAT_SHORT});
      access(1'b1, 1'b1, 1'b1, 8'h33);
      @(negedge clk);
      chk("rw_readdata_kept", readdata, 8'h5A);
      @(posedge clk);
      #1;

      // Reset in the middle of the EN pulse: pulse cut to 2 cycles, the held
      // write is replayed after POWERUP. Stall = IDLE 1 + SETUP 2 + EN 2
      // + POWERUP 10 + full write 17 = 32.
      e.rs = 1'b1; e.data = 8'h77; e.width = 2;
      en_q.push_back(e);
      e.width = P_EN;
      en_q.push_back(e);
      a.is_read = 1'b0; a.rdata = 8'h00; a.lat = 1 + P_SETUP + 2 + P_POWERUP + LAT_SHORT;
      ack_q.push_back(a);
      fork
         access(1'b0, 1'b1, 1'b1, 8'h77);
         begin
            int k;
            int guard;
            k = 0;
            guard = 0;
            while (k < 2 && guard < 200) begin
               @(negedge clk);
               guard++;
               if (lcd_en) k++;
            end
            chk("rst_en_seen", k, 2);
            reset = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("rst_mid_en_drop", lcd_en, 0);
            chk("rst_mid_readdata", readdata, 0);
            reset = 1'b1;
         end
      join
      rd_tx(1'b1, 8'h77);

      repeat (5) @(negedge clk);
      chk("en_q_drained", en_q.size(), 0);
      chk("ack_q_drained", ack_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
